// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch initiator for the 16-bit MIPS core. Owns the program counter, drives
// it straight into the combinational instruction ROM, and captures the word
// the ROM returns into a single IF/ID register that decode drains through a
// valid/ready handshake. Handles stalls, branch/jump redirects (which squash
// the IF/ID entry), and parks in an END state once the PC leaves the program.
//
// Ports
//   clk             in   clock, all state updates on the rising edge
//   rst_n           in   asynchronous active-low reset
//   fetch_en        in   1 = fetching allowed
//   cpu_pc          out  registered PC presented to the ROM
//   cpu_instruction in   ROM data for cpu_pc, same cycle
//   br_taken        in   branch redirect request
//   br_target       in   branch target address
//   jmp             in   jump redirect request, wins over br_taken
//   jmp_target      in   jump target address
//   dec_ready       in   decode accepts the IF/ID entry this cycle
//   if_valid        out  IF/ID entry valid
//   if_instruction  out  fetched instruction
//   if_pc           out  PC of if_instruction
//   fetch_done      out  high while parked in END
//   fetch_count     out  instructions accepted by decode, wraps at 16 bits
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                  PC_WIDTH   = 16,
  parameter int                  DATA_WIDTH = 16,
  parameter int                  INSTR_NUM  = 15,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  output logic [PC_WIDTH-1:0]   cpu_pc,
  input  logic [DATA_WIDTH-1:0] cpu_instruction,
  input  logic                  br_taken,
  input  logic [PC_WIDTH-1:0]   br_target,
  input  logic                  jmp,
  input  logic [PC_WIDTH-1:0]   jmp_target,
  input  logic                  dec_ready,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instruction,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic                  fetch_done,
  output logic [15:0]           fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_END  = 2'd2
  } state_t;

  // Instructions are 2 bytes, so bit 0 of any PC is always forced low.
  localparam logic [PC_WIDTH-1:0] LP_RESET_PC  = {RESET_PC[PC_WIDTH-1:1], 1'b0};
  localparam logic [PC_WIDTH-1:0] LP_INSTR_NUM = PC_WIDTH'(INSTR_NUM);
  localparam logic [PC_WIDTH-1:0] LP_PC_STEP   = PC_WIDTH'(2);

  state_t                r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [PC_WIDTH-1:0]   r_ifPc;
  logic                  r_fetchDone;
  logic [15:0]           r_count;

  logic [PC_WIDTH-1:0]   w_wordAddr;
  logic [PC_WIDTH-1:0]   w_target;
  logic [PC_WIDTH-1:0]   w_targetWord;
  logic                  w_inRange;
  logic                  w_targetInRange;
  logic                  w_redirect;
  logic                  w_transfer;
  logic                  w_load;

  // The whole word address is compared, so anything past the last ROM word
  // (including far-away targets) counts as out of program.
  assign w_wordAddr      = {1'b0, r_pc[PC_WIDTH-1:1]};
  assign w_inRange       = (w_wordAddr < LP_INSTR_NUM);

  assign w_target        = jmp ? {jmp_target[PC_WIDTH-1:1], 1'b0}
                               : {br_target[PC_WIDTH-1:1], 1'b0};
  assign w_targetWord    = {1'b0, w_target[PC_WIDTH-1:1]};
  assign w_targetInRange = (w_targetWord < LP_INSTR_NUM);

  // Redirects are only honoured once fetching has started.
  assign w_redirect      = (r_state != ST_IDLE) && (jmp || br_taken);
  assign w_transfer      = r_valid && dec_ready;
  assign w_load          = (r_state == ST_RUN) && w_inRange &&
                           (!r_valid || dec_ready) && !w_redirect;

  // Single sequential block: PC, IF/ID register, handshake counter and the
  // IDLE/RUN/END controller with its registered fetch_done flag. A redirect
  // always squashes the IF/ID entry, but a transfer that happens in the same
  // cycle is still counted. A redirect in RUN keeps the FSM in RUN so the new
  // target is range-checked on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= LP_RESET_PC;
      r_valid     <= 1'b0;
      r_instr     <= '0;
      r_ifPc      <= '0;
      r_fetchDone <= 1'b0;
      r_count     <= 16'd0;
    end else begin
      if (w_transfer) begin
        r_count <= r_count + 16'd1;
      end

      if (w_redirect) begin
        r_pc    <= w_target;
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_instr <= cpu_instruction;
        r_ifPc  <= r_pc;
        r_valid <= 1'b1;
        r_pc    <= r_pc + LP_PC_STEP;
      end else if (w_transfer) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (fetch_en) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!fetch_en) begin
            r_state <= ST_IDLE;
          end else if (!w_redirect && !w_inRange) begin
            r_state     <= ST_END;
            r_fetchDone <= 1'b1;
          end
        end
        ST_END: begin
          if (w_redirect && w_targetInRange) begin
            r_state     <= ST_RUN;
            r_fetchDone <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_fetchDone <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_pc         = r_pc;
  assign if_valid       = r_valid;
  assign if_instruction = r_instr;
  assign if_pc          = r_ifPc;
  assign fetch_done     = r_fetchDone;
  assign fetch_count    = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Drives instr_fetch_unit from a behavioural ROM (word i holds 0x1000+i) and
// compares every output on every falling edge with a cycle-level model of the
// fetch rules. Directed scenarios pin the model with literal values; a random
// phase and a long jump loop (fetch_count wrap) follow.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int NUM   = 15;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_END  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [15:0] cpu_pc;
  logic [15:0] cpu_instruction;
  logic        br_taken;
  logic [15:0] br_target;
  logic        jmp;
  logic [15:0] jmp_target;
  logic        dec_ready;
  logic        if_valid;
  logic [15:0] if_instruction;
  logic [15:0] if_pc;
  logic        fetch_done;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  // Model state: what the outputs must be after the next rising edge.
  int          mMode;
  logic [15:0] mPc;
  logic        mValid;
  logic [15:0] mInstr;
  logic [15:0] mIpc;
  logic [15:0] mCount;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .PC_WIDTH  (16),
    .DATA_WIDTH(16),
    .INSTR_NUM (NUM),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .cpu_pc         (cpu_pc),
    .cpu_instruction(cpu_instruction),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .jmp            (jmp),
    .jmp_target     (jmp_target),
    .dec_ready      (dec_ready),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .fetch_done     (fetch_done),
    .fetch_count    (fetch_count)
  );

  function automatic bit inProg(input logic [15:0] addr);
    return int'(addr >> 1) < NUM;
  endfunction

  function automatic logic [15:0] romWord(input logic [15:0] addr);
    if (inProg(addr)) return 16'h1000 + (addr >> 1);
    return 16'hBEEF ^ addr;
  endfunction

  assign cpu_instruction = romWord(cpu_pc);

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mMode  = M_IDLE;
    mPc    = 16'h0000;
    mValid = 1'b0;
    mInstr = 16'h0000;
    mIpc   = 16'h0000;
    mCount = 16'h0000;
  endtask

  // One clock of fetch behaviour, written from the rules: who may fetch,
  // what a redirect does, what a handshake does.
  task automatic modelStep();
    logic [15:0] oldPc;
    logic [15:0] tgt;
    bit          redir;
    bit          ld;
    oldPc = mPc;
    redir = (mMode != M_IDLE) && (jmp || br_taken);
    tgt   = (jmp ? jmp_target : br_target) & 16'hFFFE;
    ld    = (mMode == M_RUN) && inProg(oldPc) && !redir && (!mValid || dec_ready);
    if (mValid && dec_ready) mCount = mCount + 16'd1;
    if (ld) begin
      mInstr = romWord(oldPc);
      mIpc   = oldPc;
      mValid = 1'b1;
      mPc    = oldPc + 16'd2;
    end else if (redir || dec_ready) begin
      mValid = 1'b0;
    end
    if (redir) mPc = tgt;
    if (mMode == M_IDLE) begin
      if (fetch_en) mMode = M_RUN;
    end else if (mMode == M_RUN) begin
      if (!fetch_en) mMode = M_IDLE;
      else if (!redir && !inProg(oldPc)) mMode = M_END;
    end else begin
      if (redir && inProg(tgt)) mMode = M_RUN;
    end
  endtask

  task automatic checkOutput();
    checkVal("cpu_pc", cpu_pc, mPc);
    checkVal("if_valid", if_valid, mValid);
    checkVal("if_instruction", if_instruction, mInstr);
    checkVal("if_pc", if_pc, mIpc);
    checkVal("fetch_done", fetch_done, (mMode == M_END));
    checkVal("fetch_count", fetch_count, mCount);
  endtask

  // Called at a falling edge: set inputs, advance the model across the next
  // rising edge, then compare at the following falling edge.
  task automatic applyStimulus(input bit fe, input bit br, input logic [15:0] bt,
                               input bit j, input logic [15:0] jt, input bit dr);
    fetch_en   = fe;
    br_taken   = br;
    br_target  = bt;
    jmp        = j;
    jmp_target = jt;
    dec_ready  = dr;
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput();
  endtask

  initial begin
    int xfers;
    rst_n      = 1'b0;
    fetch_en   = 1'b0;
    br_taken   = 1'b0;
    br_target  = 16'h0;
    jmp        = 1'b0;
    jmp_target = 16'h0;
    dec_ready  = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkVal("rst_cpu_pc", cpu_pc, 16'h0000);
    checkVal("rst_if_valid", if_valid, 1'b0);
    checkVal("rst_fetch_done", fetch_done, 1'b0);
    checkVal("rst_fetch_count", fetch_count, 16'h0000);
    checkOutput();
    rst_n = 1'b1;

    // Straight-line program with decode always ready.
    applyStimulus(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 1);
      checkVal("seq_instr", if_instruction, 16'h1000 + i);
      checkVal("seq_pc", if_pc, 2 * i);
    end
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkVal("seq_done", fetch_done, 1'b1);
    checkVal("seq_count", fetch_count, 16'd15);
    checkVal("seq_cpu_pc", cpu_pc, 16'd30);

    // Stall at if_pc=4 for three cycles.
    doReset();
    repeat (4) applyStimulus(1, 0, 0, 0, 0, 1);
    checkVal("stall_pre_pc", if_pc, 16'd4);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkVal("stall_instr", if_instruction, 16'h1002);
      checkVal("stall_cpu_pc", cpu_pc, 16'd6);
    end
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkVal("stall_resume", if_instruction, 16'h1003);

    // Branch and jump together: jump wins, entry squashed.
    applyStimulus(1, 1, 16'h000A, 1, 16'h0004, 1);
    checkVal("redir_squash", if_valid, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkVal("redir_if_pc", if_pc, 16'h0004);

    // Run off the end, then branch back in, then branch out of program.
    for (int i = 0; i < 40 && !fetch_done; i++) applyStimulus(1, 0, 0, 0, 0, 1);
    checkVal("end_reached", fetch_done, 1'b1);
    applyStimulus(1, 1, 16'h0002, 0, 0, 1);
    checkVal("end_exit_done", fetch_done, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkVal("end_exit_if_pc", if_pc, 16'h0002);
    for (int i = 0; i < 40 && !fetch_done; i++) applyStimulus(1, 0, 0, 0, 0, 1);
    checkVal("end_reached2", fetch_done, 1'b1);
    applyStimulus(1, 1, 16'h0021, 0, 0, 1);
    checkVal("end_far_cpu_pc", cpu_pc, 16'h0020);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 1);
    checkVal("end_far_done", fetch_done, 1'b1);
    checkVal("end_far_valid", if_valid, 1'b0);

    // Asynchronous reset in the middle of a run.
    doReset();
    repeat (5) applyStimulus(1, 0, 0, 0, 0, 0);
    checkVal("pre_async_valid", if_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkVal("async_cpu_pc", cpu_pc, 16'h0000);
    checkVal("async_valid", if_valid, 1'b0);
    checkVal("async_instr", if_instruction, 16'h0000);
    checkVal("async_if_pc", if_pc, 16'h0000);
    checkVal("async_count", fetch_count, 16'h0000);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput();

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 11) == 0,
                      16'($urandom_range(0, 63)), $urandom_range(0, 15) == 0,
                      16'($urandom_range(0, 63)), $urandom_range(0, 3) != 0);
      end
    end

    // Looping program (jump back to 0) until 65536 transfers wrap the count.
    doReset();
    xfers = 0;
    for (int i = 0; i < 80000 && xfers < 65536; i++) begin
      if (mValid) xfers++;
      applyStimulus(1, 0, 0, (mPc == 16'd30), 16'h0000, 1);
      if (xfers == 65535) checkVal("wrap_ffff", fetch_count, 16'hFFFF);
    end
    checkVal("wrap_xfers", xfers, 65536);
    checkVal("wrap_zero", fetch_count, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
